dmem_arbiter: RTL and testbench

//  Shares the single-write/single-read data memory between two requesters: m0 = core load/store unit, m1 = DMA/debug port.

---
 rtl/dmem_arbiter.sv | 244 ++++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port arbiter in front of a word-write-only data memory
//
// Purpose:
//   Shares one single-read/single-write data memory between the core LSU (m0)
//   and the DMA/debug port (m1). One access is in flight at a time. Byte
//   addresses become word indices, and partial stores are done as a
//   read-modify-write because the memory can only write whole words.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   mX_valid_i / mX_ready_o  request handshake (X = 0, 1); ready is combinational
//   mX_we_i                  1 = store, 0 = load
//   mX_addr_i                byte address (low log2(N/8) bits ignored)
//   mX_be_i                  store byte enables (ignored for loads)
//   mX_wdata_i               store data
//   mX_rvalid_o              one-cycle response pulse, no back-pressure
//   mX_rdata_o               load data with rvalid, 0 for stores
//   mem_we_o                 memory write enable
//   mem_raddr_o, mem_waddr_o memory read/write word indices
//   mem_wdata_o              memory write data
//   mem_rdata_i              memory read data, combinational from mem_raddr_o

module dmem_arbiter #(
    parameter int N = 32,
    parameter int A = 32
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           m0_valid_i,
    output logic           m0_ready_o,
    input  logic           m0_we_i,
    input  logic [A-1:0]   m0_addr_i,
    input  logic [N/8-1:0] m0_be_i,
    input  logic [N-1:0]   m0_wdata_i,
    output logic           m0_rvalid_o,
    output logic [N-1:0]   m0_rdata_o,

    input  logic           m1_valid_i,
    output logic           m1_ready_o,
    input  logic           m1_we_i,
    input  logic [A-1:0]   m1_addr_i,
    input  logic [N/8-1:0] m1_be_i,
    input  logic [N-1:0]   m1_wdata_i,
    output logic           m1_rvalid_o,
    output logic [N-1:0]   m1_rdata_o,

    output logic           mem_we_o,
    output logic [A-1:0]   mem_raddr_o,
    output logic [A-1:0]   mem_waddr_o,
    output logic [N-1:0]   mem_wdata_o,
    input  logic [N-1:0]   mem_rdata_i
);

    localparam int BW  = N / 8;
    localparam int OFF = $clog2(BW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_RMW_RD,
        S_RMW_WR,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic            gnt_q, gnt_d;      // requester owning the current access
    logic            rr_q, rr_d;        // requester granted most recently
    logic            we_q, we_d;
    logic [A-1:0]    addr_q, addr_d;
    logic [BW-1:0]   be_q, be_d;
    logic [N-1:0]    wdata_q, wdata_d;
    logic [N-1:0]    merged_q, merged_d;
    logic [1:0]      rvalid_q, rvalid_d;
    logic [N-1:0]    rdata0_q, rdata0_d;
    logic [N-1:0]    rdata1_q, rdata1_d;

    logic            gnt_sel;
    logic            accept;
    logic            sel_we;
    logic [A-1:0]    sel_addr;
    logic [BW-1:0]   sel_be;
    logic [N-1:0]    sel_wdata;
    logic [A-1:0]    widx;
    logic            go_resp;
    logic [N-1:0]    resp_data;

    // On a tie the requester not granted last wins; rr_q resets to 1 so m0
    // takes the very first tie.
    always_comb begin
        gnt_sel = 1'b0;
        if (m0_valid_i && m1_valid_i) begin
            gnt_sel = ~rr_q;
        end else if (m1_valid_i) begin
            gnt_sel = 1'b1;
        end
    end

    // Ready is gated by rst so that every output is 0 while reset is held.
    assign accept     = (state_q == S_IDLE) && (m0_valid_i || m1_valid_i) && !rst;
    assign m0_ready_o = accept && !gnt_sel;
    assign m1_ready_o = accept &&  gnt_sel;

    always_comb begin
        if (gnt_sel) begin
            sel_we    = m1_we_i;
            sel_addr  = m1_addr_i;
            sel_be    = m1_be_i;
            sel_wdata = m1_wdata_i;
        end else begin
            sel_we    = m0_we_i;
            sel_addr  = m0_addr_i;
            sel_be    = m0_be_i;
            sel_wdata = m0_wdata_i;
        end
    end

    assign widx = addr_q >> OFF;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        merged_d    = merged_q;
        rvalid_d    = 2'b00;
        rdata0_d    = '0;
        rdata1_d    = '0;
        mem_we_o    = 1'b0;
        mem_raddr_o = '0;
        mem_waddr_o = '0;
        mem_wdata_o = '0;
        go_resp     = 1'b0;
        resp_data   = '0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    gnt_d   = gnt_sel;
                    rr_d    = gnt_sel;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    be_d    = sel_be;
                    wdata_d = sel_wdata;
                    if (!sel_we || (sel_be == '1)) begin
                        state_d = S_EXEC;
                    end else if (sel_be == '0) begin
                        // Nothing to write: complete straight away.
                        state_d = S_RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end

            S_EXEC: begin
                mem_raddr_o = widx;
                if (we_q) begin
                    mem_we_o    = 1'b1;
                    mem_waddr_o = widx;
                    mem_wdata_o = wdata_q;
                end else begin
                    resp_data = mem_rdata_i;
                end
                state_d = S_RESP;
                go_resp = 1'b1;
            end

            S_RMW_RD: begin
                mem_raddr_o = widx;
                for (int i = 0; i < BW; i++) begin
                    merged_d[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : mem_rdata_i[8*i +: 8];
                end
                state_d = S_RMW_WR;
            end

            S_RMW_WR: begin
                mem_we_o    = 1'b1;
                mem_waddr_o = widx;
                mem_wdata_o = merged_q;
                state_d     = S_RESP;
                go_resp     = 1'b1;
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Response registers are loaded on entry to RESP so rvalid/rdata
        // come straight from flops during the RESP cycle.
        if (go_resp) begin
            if (gnt_d) begin
                rvalid_d[1] = 1'b1;
                rdata1_d    = resp_data;
            end else begin
                rvalid_d[0] = 1'b1;
                rdata0_d    = resp_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            gnt_q    <= 1'b0;
            rr_q     <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
            rvalid_q <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_q     <= rr_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            merged_q <= merged_d;
            rvalid_q <= rvalid_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign m0_rvalid_o = rvalid_q[0];
    assign m1_rvalid_o = rvalid_q[1];
    assign m0_rdata_o  = rdata0_q;
    assign m1_rdata_o  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        m0_valid = 0, m0_ready, m0_we = 0, m0_rvalid;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m0_rdata;
    logic [3:0]  m0_be = 0;
    logic        m1_valid = 0, m1_ready, m1_we = 0, m1_rvalid;
    logic [31:0] m1_addr = 0, m1_wdata = 0, m1_rdata;
    logic [3:0]  m1_be = 0;
    logic        mem_we;
    logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;

    dmem_arbiter #(.N(32), .A(32)) dut (
        .clk(clk), .rst(rst),
        .m0_valid_i(m0_valid), .m0_ready_o(m0_ready), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
        .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_valid_i(m1_valid), .m1_ready_o(m1_ready), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
        .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .mem_we_o(mem_we), .mem_raddr_o(mem_raddr), .mem_waddr_o(mem_waddr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    logic [31:0] bmem  [0:255];
    logic [31:0] ref_w [0:255];
    assign mem_rdata = bmem[mem_raddr[7:0]];
    always @(posedge clk) if (mem_we) bmem[mem_waddr[7:0]] <= mem_wdata;

    typedef struct {
        logic [31:0] data;
        int          lat;
        int          t;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   glog[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   we_cnt = 0;
    int   resp_cnt = 0;
    int   pushed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Response monitor: sampled 2 ns after the falling edge.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (mem_we) we_cnt++;
            if (m0_valid && m1_valid) check("both_ready", {31'b0, m0_ready & m1_ready}, 32'd0);
            if (m0_valid && m0_ready) glog.push_back(0);
            if (m1_valid && m1_ready) glog.push_back(1);
            if (m0_rvalid) begin
                check("m0_rvalid_mem_we", {31'b0, mem_we}, 32'd0);
                check("m1_rdata_nongnt", m1_rdata, 32'd0);
                if (q0.size() == 0) begin
                    check("m0_unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    e0 = q0.pop_front();
                    resp_cnt++;
                    check("m0_rdata", m0_rdata, e0.data);
                    check("m0_latency", 32'(cyc - e0.t), 32'(e0.lat));
                end
            end
            if (m1_rvalid) begin
                check("m1_rvalid_mem_we", {31'b0, mem_we}, 32'd0);
                check("m0_rdata_nongnt", m0_rdata, 32'd0);
                if (q1.size() == 0) begin
                    check("m1_unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    e1 = q1.pop_front();
                    resp_cnt++;
                    check("m1_rdata", m1_rdata, e1.data);
                    check("m1_latency", 32'(cyc - e1.t), 32'(e1.lat));
                end
            end
        end
    end

    task automatic drive(input int p, input logic v, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        if (p == 0) begin
            m0_valid = v; m0_we = we; m0_addr = addr; m0_be = be; m0_wdata = wd;
        end else begin
            m1_valid = v; m1_we = we; m1_addr = addr; m1_be = be; m1_wdata = wd;
        end
    endtask

    // Issues one request; on handshake the reference model is updated and the
    // expected response is queued. Returns 1 ns after the accepting edge.
    task automatic issue(input int p, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        exp_t        e;
        bit          ok;
        logic [31:0] old;
        int          w;
        w  = int'(addr[9:2]);
        ok = 0;
        @(negedge clk);
        drive(p, 1'b1, we, addr, be, wd);
        #1;
        for (int i = 0; i < 40; i++) begin
            if ((p == 0 && m0_ready) || (p == 1 && m1_ready)) begin
                ok = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!ok) begin
            check(p == 0 ? "m0_ready_timeout" : "m1_ready_timeout", 32'd0, 32'd1);
            drive(p, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
            return;
        end
        old = ref_w[w];
        if (!we) begin
            e.data = old;
            e.lat  = 2;
        end else begin
            e.data = 32'd0;
            for (int b = 0; b < 4; b++) if (be[b]) old[8*b +: 8] = wd[8*b +: 8];
            ref_w[w] = old;
            e.lat = (be == 4'hF) ? 2 : (be == 4'h0) ? 1 : 3;
        end
        e.t = cyc;
        if (p == 0) q0.push_back(e); else q1.push_back(e);
        pushed++;
        @(posedge clk);
        #1;
        drive(p, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (q0.size() + q1.size()) != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("drain_empty", 32'(q0.size() + q1.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, {30'b0, m1_ready, m0_ready}, 32'd0);
        check({tag, "_rvalid"}, {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
        check({tag, "_rdata"}, m0_rdata | m1_rdata, 32'd0);
        check({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
        check({tag, "_mem_addr"}, mem_raddr | mem_waddr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    logic [31:0] saved;
    int          we_before;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            bmem[i]  = $urandom;
            ref_w[i] = bmem[i];
        end
        bmem[4]  = 32'hDEADBEEF; ref_w[4]  = 32'hDEADBEEF;
        bmem[12] = 32'h11223344; ref_w[12] = 32'h11223344;
        bmem[20] = 32'h55667788; ref_w[20] = 32'h55667788;

        // Reset state, with a request pending to show ready is held low.
        m0_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        m0_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_idle_outputs("post_reset");

        // Full-word load from m0.
        issue(0, 1'b0, 32'h10, 4'h0, 32'd0);
        @(negedge clk); #1;
        check("load_raddr", mem_raddr, 32'd4);
        check("load_no_we", {31'b0, mem_we}, 32'd0);
        drain();

        // Full-word store from m1, then readback.
        issue(1, 1'b1, 32'h20, 4'hF, 32'h12345678);
        @(negedge clk); #1;
        check("st_mem_we", {31'b0, mem_we}, 32'd1);
        check("st_waddr", mem_waddr, 32'd8);
        check("st_wdata", mem_wdata, 32'h12345678);
        @(negedge clk); #1;
        check("st_we_one_cycle", {31'b0, mem_we}, 32'd0);
        drain();
        check("st_mem_content", bmem[8], 32'h12345678);
        issue(1, 1'b0, 32'h22, 4'h0, 32'd0);
        drain();

        // Partial store via read-modify-write.
        issue(0, 1'b1, 32'h30, 4'h3, 32'hAAAABBBB);
        @(negedge clk); #1;
        check("rmw_rd_no_we", {31'b0, mem_we}, 32'd0);
        check("rmw_raddr", mem_raddr, 32'd12);
        @(negedge clk); #1;
        check("rmw_we", {31'b0, mem_we}, 32'd1);
        check("rmw_waddr", mem_waddr, 32'd12);
        check("rmw_wdata", mem_wdata, 32'h1122BBBB);
        drain();

        // be=0 store: no memory write, response after one cycle.
        we_before = we_cnt;
        issue(1, 1'b1, 32'h40, 4'h0, 32'hCAFEF00D);
        drain();
        check("be0_no_write", 32'(we_cnt - we_before), 32'd0);

        // Both requesters continuously valid: strict alternation from m0.
        glog.delete();
        fork
            for (int i = 0; i < 3; i++) issue(0, 1'b0, 32'(4 * i), 4'h0, 32'd0);
            for (int j = 0; j < 3; j++) issue(1, 1'b0, 32'(4 * j + 64), 4'h0, 32'd0);
        join
        drain();
        check("rr_count", 32'(glog.size()), 32'd6);
        for (int i = 0; i < 6 && i < glog.size(); i++) check("rr_order", 32'(glog[i]), 32'(i % 2));

        // Reset while in RMW_RD aborts the store.
        saved = ref_w[20];
        issue(0, 1'b1, 32'h50, 4'h1, 32'hFFFFFFFF);
        we_before = we_cnt;
        rst = 1'b1;
        #1;
        check_idle_outputs("abort");
        q0.delete();
        pushed--;
        ref_w[20] = saved;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_no_write", 32'(we_cnt - we_before), 32'd0);
        check("abort_mem_kept", bmem[20], 32'h55667788);

        // Random traffic from both ports against the reference model.
        fork
            for (int i = 0; i < 30; i++) begin
                int r;
                r = $urandom_range(0, 3);
                issue(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
                      r == 0 ? 4'hF : r == 1 ? 4'h0 : 4'($urandom), $urandom);
            end
            for (int j = 0; j < 30; j++) begin
                int r;
                r = $urandom_range(0, 3);
                issue(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
                      r == 0 ? 4'hF : r == 1 ? 4'h0 : 4'($urandom), $urandom);
            end
        join
        drain();
        check("resp_count", 32'(resp_cnt), 32'(pushed));
        for (int i = 0; i < 64; i++) check("final_mem", bmem[i], ref_w[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
